// File: rtl/draw_cmd_scheduler_if.sv
// ----------------------------------------------------------------------------
// draw_cmd_scheduler_if
// Bundles every non-clock/non-reset signal of draw_cmd_scheduler.
//   Command side : cmd_valid, cmd_ready, cmd_x, cmd_y, cmd_color, clear_req
//   Engine side  : eng_draw, eng_x1, eng_y1 (to engine)
//                  eng_x, eng_y, eng_wr, eng_complete (from engine)
//   VGA side     : x_out, y_out, color, write_out
//   Status       : busy, fifo_count
// The "slave" modport is the scheduler's view; "master" is the environment
// (command source, line engine and VGA sink).
// ----------------------------------------------------------------------------
interface draw_cmd_scheduler_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [8:0]    cmd_x;
    logic [8:0]    cmd_y;
    logic [2:0]    cmd_color;
    logic          clear_req;

    logic          eng_draw;
    logic [8:0]    eng_x1;
    logic [8:0]    eng_y1;
    logic [8:0]    eng_x;
    logic [8:0]    eng_y;
    logic          eng_wr;
    logic          eng_complete;

    logic [8:0]    x_out;
    logic [8:0]    y_out;
    logic [2:0]    color;
    logic          write_out;
    logic          busy;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_color, clear_req,
        input  eng_x, eng_y, eng_wr, eng_complete,
        output cmd_ready, eng_draw, eng_x1, eng_y1,
        output x_out, y_out, color, write_out, busy, fifo_count
    );

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_color, clear_req,
        output eng_x, eng_y, eng_wr, eng_complete,
        input  cmd_ready, eng_draw, eng_x1, eng_y1,
        input  x_out, y_out, color, write_out, busy, fifo_count
    );
endinterface

// File: rtl/draw_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// draw_cmd_scheduler
// Queues line-draw commands in a small FIFO and hands them one at a time to a
// line-drawing engine, forwarding the engine's pixels to the VGA write port.
// A full-screen clear sweep runs after reset and whenever requested; a pending
// clear wins over queued lines but never interrupts a line already drawing.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset (state -> CLEAR, FIFO emptied)
//   bus   : draw_cmd_scheduler_if.slave (command, engine, VGA, status)
// ----------------------------------------------------------------------------
module draw_cmd_scheduler #(
    parameter int DEPTH = 4,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic                 clk,
    input  logic                 reset,
    draw_cmd_scheduler_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [8:0]    XM      = 9'(X_MAX);
    localparam logic [8:0]    YM      = 9'(Y_MAX);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PONE_C  = AW'(1);

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [8:0]    r_x_cnt;
    logic [8:0]    r_y_cnt;
    logic          r_clear_pend;

    logic [8:0]    r_mem_x [DEPTH];
    logic [8:0]    r_mem_y [DEPTH];
    logic [2:0]    r_mem_c [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [8:0]    r_pop_x;
    logic [8:0]    r_pop_y;
    logic [2:0]    r_pop_c;

    logic [8:0]    r_eng_x1;
    logic [8:0]    r_eng_y1;
    logic [2:0]    r_line_c;
    logic          r_eng_draw;
    logic [8:0]    r_x_out;
    logic [8:0]    r_y_out;
    logic [2:0]    r_color;
    logic          r_write_out;
    logic          r_busy;

    logic          w_cmd_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_sweep_last;
    logic [8:0]    w_x_clamp;
    logic [8:0]    w_y_clamp;

    assign w_cmd_ready  = (r_count < DEPTH_C);
    assign w_push       = bus.cmd_valid & w_cmd_ready;
    // The only pop point is the IDLE->LOAD transition.
    assign w_pop        = (r_state == S_IDLE) && !r_clear_pend && (r_count != ZERO_C);
    assign w_sweep_last = (r_x_cnt == XM) && (r_y_cnt == YM);
    assign w_x_clamp    = (bus.cmd_x > XM) ? XM : bus.cmd_x;
    assign w_y_clamp    = (bus.cmd_y > YM) ? YM : bus.cmd_y;

    // Next-state logic of the scheduling FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (w_sweep_last) w_state_nxt = S_IDLE;
                else              w_state_nxt = S_CLEAR;
            end
            S_IDLE: begin
                if (r_clear_pend)            w_state_nxt = S_CLEAR;
                else if (r_count != ZERO_C)  w_state_nxt = S_LOAD;
                else                         w_state_nxt = S_IDLE;
            end
            S_LOAD:  w_state_nxt = S_DRAW;
            S_DRAW: begin
                if (bus.eng_complete) w_state_nxt = S_DONE;
                else                  w_state_nxt = S_DRAW;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // State register and busy flag (busy tracks the state being entered).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Row-major sweep counters; held at zero outside CLEAR so every entry starts at (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x_cnt <= 9'd0;
            r_y_cnt <= 9'd0;
        end else if (r_state != S_CLEAR) begin
            r_x_cnt <= 9'd0;
            r_y_cnt <= 9'd0;
        end else if (r_x_cnt == XM) begin
            r_x_cnt <= 9'd0;
            if (r_y_cnt == YM) r_y_cnt <= 9'd0;
            else               r_y_cnt <= r_y_cnt + 9'd1;
        end else begin
            r_x_cnt <= r_x_cnt + 9'd1;
        end
    end

    // Pending-clear flag: consumed when IDLE enters CLEAR, requests during CLEAR dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clear_pend <= 1'b0;
        end else if ((r_state == S_IDLE) && r_clear_pend) begin
            r_clear_pend <= 1'b0;
        end else if ((r_state != S_CLEAR) && bus.clear_req) begin
            r_clear_pend <= 1'b1;
        end else begin
            r_clear_pend <= r_clear_pend;
        end
    end

    // Command FIFO storage, pointers, occupancy and popped-entry capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_x[i] <= 9'd0;
                r_mem_y[i] <= 9'd0;
                r_mem_c[i] <= 3'd0;
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= ZERO_C;
            r_pop_x  <= 9'd0;
            r_pop_y  <= 9'd0;
            r_pop_c  <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem_x[r_wr_ptr] <= w_x_clamp;
                r_mem_y[r_wr_ptr] <= w_y_clamp;
                r_mem_c[r_wr_ptr] <= bus.cmd_color;
                r_wr_ptr          <= r_wr_ptr + PONE_C;
            end
            if (w_pop) begin
                r_pop_x  <= r_mem_x[r_rd_ptr];
                r_pop_y  <= r_mem_y[r_rd_ptr];
                r_pop_c  <= r_mem_c[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PONE_C;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

    // Engine command: endpoints latched in LOAD, run enable high exactly while in DRAW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_eng_x1   <= 9'd0;
            r_eng_y1   <= 9'd0;
            r_line_c   <= 3'd0;
            r_eng_draw <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_eng_x1 <= r_pop_x;
                r_eng_y1 <= r_pop_y;
                r_line_c <= r_pop_c;
            end
            r_eng_draw <= (w_state_nxt == S_DRAW);
        end
    end

    // VGA pixel port: sweep pixels in CLEAR, engine pass-through in DRAW, silent otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x_out     <= 9'd0;
            r_y_out     <= 9'd0;
            r_color     <= 3'd0;
            r_write_out <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_x_out     <= r_x_cnt;
                    r_y_out     <= r_y_cnt;
                    r_color     <= 3'd0;
                    r_write_out <= 1'b1;
                end
                S_DRAW: begin
                    r_x_out     <= bus.eng_x;
                    r_y_out     <= bus.eng_y;
                    r_color     <= r_line_c;
                    r_write_out <= bus.eng_wr;
                end
                default: begin
                    r_write_out <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.fifo_count = r_count;
    assign bus.busy       = r_busy;
    assign bus.eng_draw   = r_eng_draw;
    assign bus.eng_x1     = r_eng_x1;
    assign bus.eng_y1     = r_eng_y1;
    assign bus.x_out      = r_x_out;
    assign bus.y_out      = r_y_out;
    assign bus.color      = r_color;
    assign bus.write_out  = r_write_out;
endmodule

// File: tb/tb_draw_cmd_scheduler.sv
module tb_draw_cmd_scheduler;
    localparam int DEPTH = 4;
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    draw_cmd_scheduler_if #(.DEPTH(DEPTH)) bus ();

    draw_cmd_scheduler #(.DEPTH(DEPTH), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] c;
        int         cyc;
    } pix_t;

    typedef struct {
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] c;
    } line_t;

    pix_t  exp_pix[$];
    line_t exp_line[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // engine model controls/observations
    int   n_writes          = 10;
    logic eng_hold          = 1'b0;
    int   done_cnt          = 0;
    int   last_complete_cyc = 0;
    int   line_start_cyc    = 0;
    int   last_push_cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [8:0] clampv(input logic [8:0] v, input int m);
        return (int'(v) > m) ? 9'(m) : v;
    endfunction

    // Expected clear sweep: pixel i appears at cycle base+i.
    task automatic push_clear(input int base);
        int idx;
        pix_t p;
        idx = 0;
        for (int y = 0; y <= Y_MAX; y++) begin
            for (int x = 0; x <= X_MAX; x++) begin
                p.x = 9'(x); p.y = 9'(y); p.c = 3'd0; p.cyc = base + idx;
                exp_pix.push_back(p);
                idx++;
            end
        end
    endtask

    // Monitor: every VGA write is checked against the head of the scoreboard.
    always @(negedge clk) begin
        pix_t p;
        if (reset === 1'b1 && bus.write_out === 1'b1) begin
            if (exp_pix.size() == 0) begin
                fail_now($sformatf("unexpected_write x=%0d y=%0d c=%0d", bus.x_out, bus.y_out, bus.color));
            end else begin
                p = exp_pix.pop_front();
                chk("pixel_xyc", {11'd0, bus.x_out, bus.y_out, bus.color}, {11'd0, p.x, p.y, p.c});
                chk("pixel_time", 32'(cyc), 32'(p.cyc));
            end
        end
    end

    // Line engine model: checks endpoints, emits n_writes pixels, completes with the last one.
    initial begin
        line_t cur;
        pix_t  p;
        bus.eng_wr       = 1'b0;
        bus.eng_complete = 1'b0;
        bus.eng_x        = 9'd0;
        bus.eng_y        = 9'd0;
        forever begin
            @(posedge clk); #1;
            if (reset === 1'b1 && bus.eng_draw === 1'b1) begin
                line_start_cyc = cyc;
                if (exp_line.size() == 0) begin
                    fail_now($sformatf("stale_line x1=%0d y1=%0d", bus.eng_x1, bus.eng_y1));
                    cur.x = 9'd0; cur.y = 9'd0; cur.c = 3'd0;
                end else begin
                    cur = exp_line.pop_front();
                end
                chk("eng_x1_start", 32'(bus.eng_x1), 32'(cur.x));
                chk("eng_y1_start", 32'(bus.eng_y1), 32'(cur.y));
                while (eng_hold && bus.eng_draw === 1'b1) begin
                    @(posedge clk); #1;
                end
                if (bus.eng_draw !== 1'b1) continue;
                for (int k = 0; k < n_writes; k++) begin
                    bus.eng_wr       = 1'b1;
                    bus.eng_x        = 9'(cur.x + 9'(k));
                    bus.eng_y        = 9'(9'(k * 3) + 9'd7);
                    bus.eng_complete = (k == n_writes - 1);
                    p.x = bus.eng_x; p.y = bus.eng_y; p.c = cur.c; p.cyc = cyc + 1;
                    exp_pix.push_back(p);
                    chk("eng_stable", {13'd0, bus.eng_draw, bus.eng_x1, bus.eng_y1}, {13'd1, cur.x, cur.y});
                    @(posedge clk); #1;
                end
                bus.eng_wr        = 1'b0;
                bus.eng_complete  = 1'b0;
                last_complete_cyc = cyc - 1;
                done_cnt++;
                chk("eng_draw_drop", 32'(bus.eng_draw), 32'd0);
            end
        end
    end

    task automatic push_cmd(input logic [8:0] x, input logic [8:0] y, input logic [2:0] c, input int budget);
        line_t l;
        bit ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_color = c;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                last_push_cyc = cyc;
                l.x = clampv(x, X_MAX); l.y = clampv(y, Y_MAX); l.c = c;
                exp_line.push_back(l);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) fail_now($sformatf("push_timeout x=%0d y=%0d", x, y));
    endtask

    task automatic wait_done(input int prev, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (done_cnt != prev) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("line_done_timeout");
    endtask

    task automatic wait_draw(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (bus.eng_draw === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("eng_draw_timeout");
    endtask

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (exp_pix.size() == 0 && exp_line.size() == 0 &&
                bus.busy === 1'b0 && bus.fifo_count === 3'd0) begin
                ok = 1'b1; break;
            end
        end
        if (!ok) fail_now($sformatf("drain_timeout pix_left=%0d lines_left=%0d", exp_pix.size(), exp_line.size()));
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        bus.clear_req = 1'b1;
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
    endtask

    initial begin
        int prev;
        int pc;
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int pc;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = 9'd0;
        bus.cmd_y     = 9'd0;
        bus.cmd_color = 3'd0;
        bus.clear_req = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_write_out", 32'(bus.write_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_eng_draw", 32'(bus.eng_draw), 32'd0);
        chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_xy_out", {14'd0, bus.x_out, bus.y_out}, 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // power-up clear
        push_clear(cyc + 1);
        reset = 1'b1;
        wait_drain(20000);
        chk("post_clear_busy", 32'(bus.busy), 32'd0);
        chk("post_clear_write", 32'(bus.write_out), 32'd0);

        // single line, 10 writes, LOAD/DRAW/DONE/IDLE
        n_writes = 10;
        prev = done_cnt;
        push_cmd(9'd100, 9'd50, 3'd3, 10);
        pc = last_push_cyc;
        wait_done(prev, 200);
        chk("line_start_latency", 32'(line_start_cyc), 32'(pc + 3));
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_eng_draw", 32'(bus.eng_draw), 32'd0);
        @(posedge clk); #2;
        chk("idle_busy", 32'(bus.busy), 32'd0);
        wait_drain(200);

        // FIFO full while the engine is stalled
        n_writes = 4;
        eng_hold = 1'b1;
        push_cmd(9'd10, 9'd20, 3'd1, 10);
        wait_draw(50);
        push_cmd(9'd11, 9'd21, 3'd2, 10);
        push_cmd(9'd12, 9'd22, 3'd4, 10);
        push_cmd(9'd13, 9'd23, 3'd5, 10);
        push_cmd(9'd14, 9'd24, 3'd6, 10);
        @(negedge clk);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        chk("full_ready", 32'(bus.cmd_ready), 32'd0);
        fork
            push_cmd(9'd15, 9'd25, 3'd7, 500);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_ready_hold", 32'(bus.cmd_ready), 32'd0);
                end
                @(posedge clk); #1;
                eng_hold = 1'b0;
            end
        join
        wait_drain(2000);

        // clear requested mid-line with two lines queued
        n_writes = 6;
        eng_hold = 1'b1;
        push_cmd(9'd30, 9'd40, 3'd2, 10);
        wait_draw(50);
        push_cmd(9'd31, 9'd41, 3'd3, 10);
        push_cmd(9'd32, 9'd42, 3'd4, 10);
        pulse_clear();
        prev = done_cnt;
        eng_hold = 1'b0;
        wait_done(prev, 200);
        push_clear(last_complete_cyc + 4);
        repeat (300) @(posedge clk);
        #1;
        chk("mid_clear_busy", 32'(bus.busy), 32'd1);
        pulse_clear();
        wait_drain(25000);

        // endpoint clamping
        n_writes = 3;
        push_cmd(9'd300, 9'd200, 3'd5, 10);
        wait_drain(200);

        // reset during DRAW with three queued
        eng_hold = 1'b1;
        push_cmd(9'd50, 9'd60, 3'd1, 10);
        wait_draw(50);
        push_cmd(9'd51, 9'd61, 3'd2, 10);
        push_cmd(9'd52, 9'd62, 3'd3, 10);
        push_cmd(9'd53, 9'd63, 3'd4, 10);
        @(negedge clk);
        chk("pre_reset_count", 32'(bus.fifo_count), 32'd3);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("async_eng_draw", 32'(bus.eng_draw), 32'd0);
        chk("async_fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd1);
        exp_line.delete();
        exp_pix.delete();
        eng_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_clear(cyc + 1);
        reset = 1'b1;
        wait_drain(25000);
        repeat (20) @(posedge clk);
        #2;
        chk("final_busy", 32'(bus.busy), 32'd0);
        chk("final_fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("final_pix_left", 32'(exp_pix.size()), 32'd0);
        chk("final_lines_left", 32'(exp_line.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_cmd_scheduler.md
Name: draw_cmd_scheduler

Overview:
Sequences line-draw commands onto the shared line-drawing engine and VGA pixel write port. A small command FIFO accepts endpoint and colour requests. Commands are dispatched one at a time to the engine over a draw/complete handshake. A full-screen clear sweep runs after reset and on request, and clear takes priority over queued lines.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
X_MAX, 159, last screen column
Y_MAX, 119, last screen row

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_x  in  9  line endpoint x
cmd_y  in  9  line endpoint y
cmd_color  in  3  line colour
clear_req  in  1  one-cycle pulse requesting a screen clear
eng_draw  out  1  engine run enable (held high for the whole line)
eng_x1  out  9  endpoint x to engine, stable while eng_draw=1
eng_y1  out  9  endpoint y to engine, stable while eng_draw=1
eng_x  in  9  engine pixel x
eng_y  in  9  engine pixel y
eng_wr  in  1  engine pixel valid
eng_complete  in  1  engine finished the line
x_out  out  9  pixel x to VGA
y_out  out  9  pixel y to VGA
color  out  3  pixel colour to VGA
write_out  out  1  VGA pixel write enable
busy  out  1  high in any state other than IDLE
fifo_count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low. While reset=0, all registers clear, the FIFO empties, the state is CLEAR and the x/y sweep counters are 0.
- Registered outputs: x_out, y_out, color, write_out and eng_* reset to 0. busy resets to 1 (reset state is CLEAR).
- Output latency: x_out/y_out/color/write_out are registered, so each appears 1 cycle after its source (sweep counter or engine).
- FIFO:
  - cmd_ready = (fifo_count < DEPTH).
  - Push on cmd_valid & cmd_ready. cmd_x is clamped to X_MAX and cmd_y to Y_MAX on push.
  - Pop only on the IDLE->LOAD transition.
  - Push and pop in the same cycle leaves the count unchanged.
  - When full, cmd_ready stays 0 even in a pop cycle.
- clear_pend flag:
  - Set by clear_req in any state except CLEAR.
  - Cleared on entry to CLEAR.
  - A clear_req arriving during CLEAR is ignored.
- States:
  - CLEAR:
    - Sweep is row-major: x counts 0..X_MAX, then wraps to 0 and y increments; y runs 0..Y_MAX.
    - Each cycle emits write_out=1, colour 0 at (x,y); eng_draw=0.
    - At (X_MAX,Y_MAX), emit the last pixel, then go to IDLE. A full clear takes (X_MAX+1)*(Y_MAX+1) = 19200 cycles.
    - Counters reset to 0 on every entry to CLEAR.
  - IDLE:
    - write_out=0.
    - If clear_pend, go to CLEAR. Else if the FIFO is not empty, pop and go to LOAD. Else stay.
  - LOAD (1 cycle):
    - Latch the popped x, y and colour into eng_x1/eng_y1/line colour.
    - write_out=0; next state is DRAW.
  - DRAW:
    - eng_draw=1.
    - Registered pass-through: write_out<=eng_wr, x_out<=eng_x, y_out<=eng_y, color<=latched colour.
    - On eng_complete=1, go to DONE. The pixel accompanying eng_wr in the complete cycle is still forwarded.
  - DONE (1 cycle):
    - eng_draw=0 so the engine re-arms; write_out=0; next state is IDLE.
- Priority: a pending clear beats queued lines, but never aborts a line in progress. The line finishes first, then CLEAR runs, then the queue resumes.
- FIFO during CLEAR/DRAW: keeps accepting pushes.
- Reset mid-operation: any state returns immediately to CLEAR. eng_draw drops to 0 asynchronously and queued commands are discarded.
- eng_complete outside DRAW: ignored.

Test Plan:
- Release reset with no commands: write_out=1 for exactly 19200 consecutive cycles, covering (0,0)..(159,119) row-major with color=0. Then busy=0 and write_out=0.
- After the clear, push (x=100,y=50,c=3) with an engine model completing after 10 writes: eng_x1=100 and eng_y1=50 are stable under eng_draw. 10 writes appear with color=3, each 1 cycle after eng_wr. The sequence is LOAD, DRAW, DONE, IDLE.
- Push 5 commands back-to-back while DRAW is stalled (DEPTH=4): the first 4 are accepted with fifo_count=4. cmd_ready=0 on the 5th, which is held until a pop, then accepted. All 5 are drawn in push order.
- Pulse clear_req mid-line with 2 commands queued: the current line completes, a 19200-cycle clear follows, then both queued lines draw. A second clear_req during CLEAR causes no extra clear.
- Push (x=300,y=200): eng_x1=159, eng_y1=119.
- Assert reset during DRAW with 3 queued: eng_draw=0 and fifo_count=0 immediately. After release, a full clear runs and no stale line is drawn.
